hazard_stall_ctrl: RTL and testbench

HAZARD_STALL_CTRL -- requirements
Module: hazard_stall_ctrl

---
 rtl/hazard_stall_ctrl.sv | 132 +++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard detection: load-use, branch-operand and mult/div-busy stalls,
// plus the mult/div occupancy sequencer and a saturating stall-cycle counter.
module hazard_stall_ctrl #(
   parameter int MULT_CYC = 5,
   parameter int DIV_CYC  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] instr_D,
   input  logic [31:0] instr_E,
   input  logic [31:0] instr_M,
   output logic        En_PC,
   output logic        En_FD,
   output logic        clr_DE,
   output logic        md_busy,
   output logic        md_done,
   output logic [31:0] stall_cnt
);

   localparam int MAX_CYC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
   localparam int CW      = $clog2(MAX_CYC + 1);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] md_cnt_q, md_cnt_d;
   logic [31:0]   stall_cnt_q, stall_cnt_d;

   logic [5:0] op_D, op_E, op_M, funct_D, funct_E;
   logic [4:0] rs_D, rt_D, rt_E, rd_E, rt_M, dst_E;
   logic       rs_rd_D, rt_rd_D, wr_E, br_D, md_D, md_start_E;
   logic       stall_lu, stall_br, stall_md, stall;
   logic       unused;

   function automatic logic is_load(input logic [5:0] op);
      return op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25};
   endfunction

   function automatic logic is_alu_wr(input logic [5:0] op, input logic [5:0] funct);
      if (op == 6'h00)
         return !(funct inside {6'h08, 6'h11, 6'h13, [6'h18:6'h1B]});
      return op inside {[6'h08:6'h0F]};
   endfunction

   // A destination of $0 never creates a hazard.
   function automatic logic src_hit(input logic [4:0] r, input logic [4:0] rs, input logic [4:0] rt,
                                    input logic rs_rd, input logic rt_rd);
      return (r != 5'd0) && ((rs_rd && (r == rs)) || (rt_rd && (r == rt)));
   endfunction

   assign op_D    = instr_D[31:26];
   assign rs_D    = instr_D[25:21];
   assign rt_D    = instr_D[20:16];
   assign funct_D = instr_D[5:0];
   assign op_E    = instr_E[31:26];
   assign rt_E    = instr_E[20:16];
   assign rd_E    = instr_E[15:11];
   assign funct_E = instr_E[5:0];
   assign op_M    = instr_M[31:26];
   assign rt_M    = instr_M[20:16];
   assign unused  = ^{instr_D[15:6], instr_E[25:21], instr_E[10:6], instr_M[25:21], instr_M[15:0]};

   always_comb begin
      rs_rd_D    = !(op_D inside {6'h02, 6'h03, 6'h0F});
      rt_rd_D    = (op_D == 6'h00) || (op_D inside {6'h04, 6'h05, 6'h28, 6'h29, 6'h2B});
      dst_E      = (op_E == 6'h00) ? rd_E : rt_E;
      wr_E       = is_load(op_E) || is_alu_wr(op_E, funct_E);
      br_D       = (op_D inside {6'h04, 6'h05}) ||
                   ((op_D == 6'h00) && (funct_D inside {6'h08, 6'h09}));
      md_D       = (op_D == 6'h00) && (funct_D inside {[6'h10:6'h13], [6'h18:6'h1B]});
      md_start_E = (op_E == 6'h00) && (funct_E inside {[6'h18:6'h1B]});

      stall_lu = is_load(op_E) && src_hit(rt_E, rs_D, rt_D, rs_rd_D, rt_rd_D);
      stall_br = br_D && ((wr_E && src_hit(dst_E, rs_D, rt_D, rs_rd_D, rt_rd_D)) ||
                          (is_load(op_M) && src_hit(rt_M, rs_D, rt_D, rs_rd_D, rt_rd_D)));
      stall_md = md_D && (md_busy || md_start_E);
      stall    = stall_lu | stall_br | stall_md;
   end

   assign En_PC     = ~stall;
   assign En_FD     = ~stall;
   assign clr_DE    = stall;
   assign md_busy   = (md_cnt_q != '0);
   assign stall_cnt = stall_cnt_q;

   always_comb begin
      state_d  = state_q;
      md_cnt_d = md_cnt_q;
      md_done  = 1'b0;
      case (state_q)
         IDLE: begin
            if (md_start_E && (md_cnt_q == '0)) begin
               state_d  = BUSY;
               md_cnt_d = funct_E[1] ? CW'(DIV_CYC) : CW'(MULT_CYC);
            end
         end
         BUSY: begin
            // A start seen here is dropped: the unit is occupied.
            if (md_cnt_q <= CW'(1)) begin
               md_done  = (md_cnt_q == CW'(1));
               md_cnt_d = '0;
               state_d  = IDLE;
            end else begin
               md_cnt_d = md_cnt_q - CW'(1);
            end
         end
         default: begin
            state_d  = IDLE;
            md_cnt_d = '0;
         end
      endcase
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall && (stall_cnt_q != 32'hFFFF_FFFF))
         stall_cnt_d = stall_cnt_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         md_cnt_q    <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         md_cnt_q    <= md_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: directed vector table, multi-cycle
// mult/div/reset/saturation sequences and randomized traffic against a register-mask model.
module tb_hazard_stall_ctrl;

   localparam int MULT_N = 5;
   localparam int DIV_N  = 10;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] instr_D = '0, instr_E = '0, instr_M = '0;
   logic        En_PC, En_FD, clr_DE, md_busy, md_done;
   logic [31:0] stall_cnt;

   int          checks = 0;
   int          errors = 0;

   longint      cyc = 0;
   longint      busy_end = 0;
   logic [31:0] m_cnt = '0;

   logic [5:0]  fn_pool [15] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h08, 6'h09, 6'h10, 6'h11,
                                 6'h12, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B, 6'h00};
   logic [5:0]  op_pool [13] = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h2B, 6'h04, 6'h05,
                                 6'h08, 6'h0D, 6'h0F, 6'h02, 6'h03};

   hazard_stall_ctrl #(.MULT_CYC(MULT_N), .DIV_CYC(DIV_N)) dut (
      .clk(clk), .reset(reset), .instr_D(instr_D), .instr_E(instr_E), .instr_M(instr_M),
      .En_PC(En_PC), .En_FD(En_FD), .clr_DE(clr_DE), .md_busy(md_busy),
      .md_done(md_done), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input int fn);
      return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
   endfunction

   function automatic logic [31:0] itype(input int op, input int rs, input int rt);
      return {6'(op), 5'(rs), 5'(rt), 16'h0004};
   endfunction

   // Model: set of architectural registers each instruction reads, and what it writes.
   function automatic logic [31:0] read_set(input logic [31:0] i);
      logic [31:0] s = '0;
      int op = int'(i[31:26]);
      if (op != 2 && op != 3 && op != 15) s[i[25:21]] = 1'b1;
      if (op == 0 || op == 4 || op == 5 || op == 'h28 || op == 'h29 || op == 'h2B) s[i[20:16]] = 1'b1;
      return s;
   endfunction

   function automatic bit load_op(input logic [31:0] i);
      int op = int'(i[31:26]);
      return op == 'h20 || op == 'h21 || op == 'h23 || op == 'h24 || op == 'h25;
   endfunction

   function automatic int writes(input logic [31:0] i);
      int op = int'(i[31:26]);
      int fn = int'(i[5:0]);
      if (load_op(i)) return int'(i[20:16]);
      if (op >= 8 && op <= 15) return int'(i[20:16]);
      if (op == 0 && !(fn == 8 || fn == 'h11 || fn == 'h13 || (fn >= 'h18 && fn <= 'h1B)))
         return int'(i[15:11]);
      return 0;
   endfunction

   function automatic bit md_start(input logic [31:0] i);
      return i[31:26] == 0 && i[5:0] >= 'h18 && i[5:0] <= 'h1B;
   endfunction

   function automatic bit model_stall(input logic [31:0] d, input logic [31:0] e,
                                      input logic [31:0] m, input bit busy);
      logic [31:0] rs = read_set(d);
      int  fd = int'(d[5:0]);
      bit  br = (d[31:26] == 4 || d[31:26] == 5) || (d[31:26] == 0 && (fd == 8 || fd == 9));
      bit  mdd = d[31:26] == 0 && ((fd >= 'h10 && fd <= 'h13) || (fd >= 'h18 && fd <= 'h1B));
      int  we = writes(e);
      bit  lu = load_op(e) && e[20:16] != 0 && rs[e[20:16]];
      bit  bh = br && ((we != 0 && rs[we]) || (load_op(m) && m[20:16] != 0 && rs[m[20:16]]));
      return lu || bh || (mdd && (busy || md_start(e)));
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step(input logic [31:0] d, input logic [31:0] e, input logic [31:0] m, input logic r);
      bit busy, done, st;
      @(negedge clk);
      instr_D = d; instr_E = e; instr_M = m; reset = r;
      #1;
      busy = cyc < busy_end;
      done = busy && (cyc == busy_end - 1);
      st   = model_stall(d, e, m, busy);
      check("En_PC", 32'(En_PC), 32'(!st));
      check("En_FD", 32'(En_FD), 32'(!st));
      check("clr_DE", 32'(clr_DE), 32'(st));
      check("md_busy", 32'(md_busy), 32'(busy));
      check("md_done", 32'(md_done), 32'(done));
      check("stall_cnt", stall_cnt, m_cnt);
      if (r) begin
         busy_end = 0;
         m_cnt    = '0;
      end else begin
         if (st && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
         if (md_start(e) && !busy) busy_end = cyc + 1 + ((e[1]) ? DIV_N : MULT_N);
      end
      cyc++;
   endtask

   function automatic logic [31:0] rnd_instr();
      int k = $urandom_range(0, 9);
      int a = $urandom_range(0, 3), b = $urandom_range(0, 3), c = $urandom_range(0, 3);
      if (k < 4) return rtype(a, b, c, int'(fn_pool[$urandom_range(0, 14)]));
      if (k == 4) return '0;
      return itype(int'(op_pool[$urandom_range(0, 12)]), a, b);
   endfunction

   typedef struct {
      logic [31:0] d, e, m;
      logic        exp;
   } vec_t;

   vec_t tbl [13];

   initial begin
      int nb, done_at, free_at;

      tbl[0]  = '{rtype(8, 0, 10, 'h20), itype('h23, 0, 8), '0, 1'b1};
      tbl[1]  = '{rtype(0, 0, 10, 'h20), itype('h23, 0, 0), '0, 1'b0};
      tbl[2]  = '{itype(4, 9, 0), rtype(1, 2, 9, 'h21), '0, 1'b1};
      tbl[3]  = '{itype(5, 0, 9), '0, itype('h23, 0, 9), 1'b1};
      tbl[4]  = '{rtype(9, 0, 10, 'h20), rtype(1, 2, 9, 'h21), '0, 1'b0};
      tbl[5]  = '{itype('h0F, 9, 1), itype('h23, 0, 9), '0, 1'b0};
      tbl[6]  = '{itype(8, 0, 9), itype('h23, 0, 9), '0, 1'b0};
      tbl[7]  = '{itype('h2B, 1, 9), itype('h23, 0, 9), '0, 1'b1};
      tbl[8]  = '{rtype(5, 0, 0, 8), itype(8, 0, 5), '0, 1'b1};
      tbl[9]  = '{rtype(0, 0, 3, 'h12), rtype(1, 2, 0, 'h18), '0, 1'b1};
      tbl[10] = '{rtype(1, 2, 3, 'h20), rtype(1, 2, 0, 'h18), '0, 1'b0};
      tbl[11] = '{itype(4, 7, 0), rtype(7, 0, 7, 'h11), '0, 1'b0};
      tbl[12] = '{itype(4, 9, 0), '0, rtype(1, 2, 9, 'h21), 1'b0};

      repeat (2) @(negedge clk);
      step('0, '0, '0, 1'b0);
      check("rst_En_PC", 32'(En_PC), 32'd1);
      check("rst_clr_DE", 32'(clr_DE), 32'd0);
      check("rst_md_busy", 32'(md_busy), 32'd0);
      check("rst_stall_cnt", stall_cnt, 32'd0);

      foreach (tbl[i]) begin
         step('0, '0, '0, 1'b1);
         step(tbl[i].d, tbl[i].e, tbl[i].m, 1'b0);
         check($sformatf("tbl%0d_stall", i), 32'(clr_DE), 32'(tbl[i].exp));
      end
      step('0, '0, '0, 1'b0);
      check("lu_cnt", stall_cnt, 32'd0);

      // mult then mflo held in Decode
      step('0, '0, '0, 1'b1);
      step(rtype(0, 0, 3, 'h12), rtype(1, 2, 0, 'h18), '0, 1'b0);
      check("mult_start_stall", 32'(clr_DE), 32'd1);
      nb = 0; done_at = -1; free_at = -1;
      for (int k = 1; k <= 8; k++) begin
         step(rtype(0, 0, 3, 'h12), '0, '0, 1'b0);
         nb += int'(md_busy);
         if (md_done) done_at = k;
         if (!md_busy && free_at < 0) begin
            free_at = k;
            check("mflo_issue", 32'(clr_DE), 32'd0);
         end
      end
      check("mult_busy_len", 32'(nb), 32'd5);
      check("mult_done_at", 32'(done_at), 32'd5);
      check("mult_free_at", 32'(free_at), 32'd6);

      // divu back-to-back: second start ignored
      step('0, '0, '0, 1'b1);
      step('0, rtype(1, 2, 0, 'h1B), '0, 1'b0);
      nb = 0;
      step('0, rtype(1, 2, 0, 'h1B), '0, 1'b0);
      nb += int'(md_busy);
      for (int k = 0; k < 12; k++) begin
         step('0, '0, '0, 1'b0);
         nb += int'(md_busy);
      end
      check("divu_busy_len", 32'(nb), 32'd10);

      // reset in the cycle the divide counter shows 4
      step('0, '0, '0, 1'b1);
      step(rtype(0, 0, 3, 'h10), rtype(1, 2, 0, 'h1A), '0, 1'b0);
      for (int k = 0; k < 6; k++) step(rtype(0, 0, 3, 'h10), '0, '0, 1'b0);
      step('0, '0, '0, 1'b1);
      step('0, '0, '0, 1'b0);
      check("rstdiv_busy", 32'(md_busy), 32'd0);
      check("rstdiv_done", 32'(md_done), 32'd0);
      check("rstdiv_cnt", stall_cnt, 32'd0);

      // randomized traffic
      for (int k = 0; k < 3000; k++)
         step(rnd_instr(), rnd_instr(), rnd_instr(), ($urandom_range(0, 99) == 0));

      // saturation
      step('0, '0, '0, 1'b1);
      step('0, '0, '0, 1'b0);
      @(negedge clk);
      force dut.stall_cnt_q = 32'hFFFF_FFFE;
      #1;
      release dut.stall_cnt_q;
      m_cnt = 32'hFFFF_FFFE;
      cyc++;
      step(rtype(8, 0, 10, 'h20), itype('h23, 0, 8), '0, 1'b0);
      step(rtype(8, 0, 10, 'h20), itype('h23, 0, 8), '0, 1'b0);
      step('0, '0, '0, 1'b0);
      check("sat_max", stall_cnt, 32'hFFFF_FFFF);
      step(rtype(8, 0, 10, 'h20), itype('h23, 0, 8), '0, 1'b0);
      step('0, '0, '0, 1'b0);
      check("sat_hold", stall_cnt, 32'hFFFF_FFFF);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
